cpu_divider: RTL and testbench

CPU_DIVIDER -- requirements
Module: cpu_divider

---
 rtl/cpu_divider.sv | 136 +++++++++++++
 tb/tb_cpu_divider.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_divider.sv
// Iterative 32-bit restoring divider: one quotient bit per clock, fixed latency,
// result held with its destination register until the writeback port acknowledges it.
module cpu_divider (
    input  logic        clock,
    input  logic        reset,
    input  logic        p3_div_start,
    input  logic [31:0] p3_numerator,
    input  logic [31:0] p3_denominator,
    input  logic        p3_div_sign,
    input  logic        p3_div_mod,
    input  logic [4:0]  p3_latent_dest,
    input  logic        div_ack,
    output logic        div_busy,
    output logic        div_valid,
    output logic [31:0] div_result,
    output logic [4:0]  div_dest
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: div_valid stays high in DONE, holding div_result/div_dest steady,
    // until a cycle with div_ack=1; that rising edge consumes the result.
    state_t      state;
    state_t      state_next;

    logic [31:0] num_q;
    logic [31:0] den_q;
    logic        sign_q;
    logic        mod_q;
    logic [4:0]  dest_q;
    logic [32:0] rem_q;
    logic [31:0] quot_q;
    logic [4:0]  count_q;

    logic [32:0] rem_shift;
    logic        step_fits;
    logic [32:0] rem_step;
    logic [31:0] quot_step;
    logic [31:0] final_mag;
    logic [31:0] final_val;
    logic        start_accept;
    logic        last_step;

    // The counter doubles as the index of the numerator bit consumed this step,
    // so the captured numerator never has to shift.
    always_comb begin
        rem_shift = {rem_q[31:0], num_q[count_q]};
        step_fits = (rem_shift >= {1'b0, den_q});
        rem_step  = step_fits ? (rem_shift - {1'b0, den_q}) : rem_shift;
        quot_step = {quot_q[30:0], step_fits};
        final_mag = mod_q ? rem_step[31:0] : quot_step;
        final_val = sign_q ? (32'd0 - final_mag) : final_mag;
    end

    always_comb begin
        start_accept = (state == IDLE) && p3_div_start;
        last_step    = (state == RUN) && (count_q == 5'd0);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (p3_div_start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (count_q == 5'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (div_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            num_q   <= 32'd0;
            den_q   <= 32'd0;
            sign_q  <= 1'b0;
            mod_q   <= 1'b0;
            dest_q  <= 5'd0;
            rem_q   <= 33'd0;
            quot_q  <= 32'd0;
            count_q <= 5'd0;
        end else if (start_accept) begin
            num_q   <= p3_numerator;
            den_q   <= p3_denominator;
            sign_q  <= p3_div_sign;
            mod_q   <= p3_div_mod;
            dest_q  <= p3_latent_dest;
            rem_q   <= 33'd0;
            quot_q  <= 32'd0;
            count_q <= 5'd31;
        end else if (state == RUN) begin
            rem_q   <= rem_step;
            quot_q  <= quot_step;
            count_q <= count_q - 5'd1;
        end
    end

    // Output registers load only on the final step, so they stay frozen in DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_result <= 32'd0;
            div_dest   <= 5'd0;
        end else if (last_step) begin
            div_result <= final_val;
            div_dest   <= dest_q;
        end
    end

    always_comb begin
        div_busy  = (state != IDLE);
        div_valid = (state == DONE);
    end

endmodule

// File: tb/tb_cpu_divider.sv
// Directed and randomized bench for cpu_divider; expected results come from a
// plain-arithmetic divide model.
module tb_cpu_divider;

    logic        clock;
    logic        reset;
    logic        p3_div_start;
    logic [31:0] p3_numerator;
    logic [31:0] p3_denominator;
    logic        p3_div_sign;
    logic        p3_div_mod;
    logic [4:0]  p3_latent_dest;
    logic        div_ack;
    logic        div_busy;
    logic        div_valid;
    logic [31:0] div_result;
    logic [4:0]  div_dest;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    cpu_divider dut (
        .clock          (clock),
        .reset          (reset),
        .p3_div_start   (p3_div_start),
        .p3_numerator   (p3_numerator),
        .p3_denominator (p3_denominator),
        .p3_div_sign    (p3_div_sign),
        .p3_div_mod     (p3_div_mod),
        .p3_latent_dest (p3_latent_dest),
        .div_ack        (div_ack),
        .div_busy       (div_busy),
        .div_valid      (div_valid),
        .div_result     (div_result),
        .div_dest       (div_dest)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // reference model: unsigned divide, /0 gives all-ones quotient, remainder = numerator
    function automatic logic [31:0] model(input logic [31:0] num, input logic [31:0] den,
                                          input logic sign, input logic mod);
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] v;
        if (den == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = num;
        end else begin
            q = num / den;
            r = num % den;
        end
        v = mod ? r : q;
        return sign ? (32'd0 - v) : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver: present a start for one cycle; returns at the negedge of cycle 1
    task automatic drive_start(input logic [31:0] num, input logic [31:0] den,
                               input logic sign, input logic mod, input logic [4:0] dest);
        @(negedge clock);
        p3_div_start   = 1'b1;
        p3_numerator   = num;
        p3_denominator = den;
        p3_div_sign    = sign;
        p3_div_mod     = mod;
        p3_latent_dest = dest;
        exp_q.push_back(model(num, den, sign, mod));
        @(negedge clock);
        p3_div_start   = 1'b0;
        p3_numerator   = $urandom;
        p3_denominator = $urandom;
    endtask

    // advances negedge by negedge from cycle cyc_in until div_valid or the budget ends
    task automatic wait_valid(input int cyc_in, output int cyc_out);
        int cyc;
        cyc = cyc_in;
        while (!div_valid && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        cyc_out = cyc;
    endtask

    task automatic drive_ack();
        div_ack = 1'b1;
        @(negedge clock);
        div_ack = 1'b0;
    endtask

    // scoreboard: compare the presented result with the oldest expectation
    task automatic score(input string tag, input logic [4:0] dest);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue: observed empty expected one entry", tag);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_result"}, div_result, exp);
            check({tag, "_dest"}, {27'd0, div_dest}, {27'd0, dest});
        end
    endtask

    task automatic full_divide(input string tag, input logic [31:0] num, input logic [31:0] den,
                               input logic sign, input logic mod, input logic [4:0] dest);
        int cyc;
        drive_start(num, den, sign, mod, dest);
        wait_valid(1, cyc);
        check({tag, "_latency"}, cyc, 33);
        score(tag, dest);
        drive_ack();
        check({tag, "_idle_busy"}, {31'd0, div_busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        logic [31:0] held_res;
        logic [4:0]  held_dest;
        logic [31:0] n;
        logic [31:0] d;
        logic [4:0]  ds;
        logic        sg;
        logic        md;

        reset          = 1'b0;
        p3_div_start   = 1'b0;
        p3_numerator   = 32'd0;
        p3_denominator = 32'd0;
        p3_div_sign    = 1'b0;
        p3_div_mod     = 1'b0;
        p3_latent_dest = 5'd0;
        div_ack        = 1'b0;

        #12;
        check("reset_busy", {31'd0, div_busy}, 32'd0);
        check("reset_valid", {31'd0, div_valid}, 32'd0);
        check("reset_result", div_result, 32'd0);
        check("reset_dest", {27'd0, div_dest}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // unsigned divide with explicit busy/valid timing
        drive_start(32'd100, 32'd7, 1'b0, 1'b0, 5'd5);
        check("udiv_busy_c1", {31'd0, div_busy}, 32'd1);
        check("udiv_valid_c1", {31'd0, div_valid}, 32'd0);
        wait_valid(1, cyc);
        check("udiv_latency", cyc, 33);
        check("udiv_literal", div_result, 32'd14);
        score("udiv", 5'd5);
        drive_ack();
        check("udiv_valid_after_ack", {31'd0, div_valid}, 32'd0);

        // signed quotient / remainder
        full_divide("sq", 32'd7, 32'd2, 1'b1, 1'b0, 5'd1);
        full_divide("sr", 32'd7, 32'd2, 1'b1, 1'b1, 5'd2);

        // divide by zero
        full_divide("dz_q", 32'h1234_5678, 32'd0, 1'b0, 1'b0, 5'd3);
        full_divide("dz_r", 32'h1234_5678, 32'd0, 1'b0, 1'b1, 5'd4);

        // large operands
        full_divide("big_r", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 5'd30);
        full_divide("big_q", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd31);

        // backpressure: start in RUN and DONE ignored, outputs held until ack
        drive_start(32'd1000, 32'd33, 1'b0, 1'b0, 5'd9);
        repeat (9) @(negedge clock);
        p3_div_start   = 1'b1;
        p3_numerator   = 32'd5;
        p3_denominator = 32'd5;
        p3_latent_dest = 5'd20;
        @(negedge clock);
        p3_div_start   = 1'b0;
        wait_valid(11, cyc);
        check("bp_latency", cyc, 33);
        held_res  = div_result;
        held_dest = div_dest;
        score("bp", 5'd9);
        for (int i = 0; i < 5; i++) begin
            p3_div_start = (i == 2);
            @(negedge clock);
            check("bp_hold_valid", {31'd0, div_valid}, 32'd1);
            check("bp_hold_result", div_result, held_res);
            check("bp_hold_dest", {27'd0, div_dest}, {27'd0, held_dest});
        end
        p3_div_start = 1'b0;
        drive_ack();
        check("bp_ack_busy", {31'd0, div_busy}, 32'd0);
        check("bp_ack_valid", {31'd0, div_valid}, 32'd0);
        repeat (3) @(negedge clock);
        check("bp_no_second_op", {31'd0, div_busy}, 32'd0);

        // reset mid-operation, then a fresh divide right after release
        drive_start(32'd999, 32'd3, 1'b0, 1'b0, 5'd7);
        void'(exp_q.pop_back());
        repeat (14) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, div_busy}, 32'd0);
        check("rst_mid_valid", {31'd0, div_valid}, 32'd0);
        check("rst_mid_result", div_result, 32'd0);
        check("rst_mid_dest", {27'd0, div_dest}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        full_divide("post_rst", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 5'd11);

        // randomized divides
        for (int k = 0; k < 20; k++) begin
            n  = $urandom;
            case ($urandom_range(0, 3))
                0: d = 32'd0;
                1: d = 32'($urandom_range(1, 255));
                2: d = n >> $urandom_range(0, 31);
                default: d = $urandom;
            endcase
            sg = 1'($urandom_range(0, 1));
            md = 1'($urandom_range(0, 1));
            ds = 5'($urandom_range(0, 31));
            full_divide("rand", n, d, sg, md, ds);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
